// File: rtl/mips_pkg.sv
// Shared MIPS definitions: PC-source selects, fetch FSM states, and opcode constants.
package mips_pkg;

  localparam logic [1:0] PCSRC_NONE   = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10,
    S_ERR  = 2'b11
  } fetch_state_t;

  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect target: J/JAL region jump, PC-relative branch, or register jump.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [1:0]  redirect_src,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] redirect_imm16,
  input  logic [25:0] redirect_tgt26,
  input  logic [31:0] redirect_rs,
  output logic [31:0] target
);

  logic        [31:0] w_pc_plus1;
  logic signed [31:0] w_offset;

  assign w_pc_plus1 = redirect_pc + 32'd1;
  assign w_offset   = {{16{redirect_imm16[15]}}, redirect_imm16};

  always_comb begin
    target = w_pc_plus1;
    case (redirect_src)
      PCSRC_JUMP:   target = {w_pc_plus1[31:26], redirect_tgt26};
      PCSRC_BRANCH: target = w_pc_plus1 + w_offset;
      PCSRC_JR:     target = redirect_rs;
      default:      target = w_pc_plus1;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: owns the word PC, keeps one imem request in flight, holds the
// fetched word for decode, and applies datapath redirects by squashing stale fetches.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_src,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] redirect_imm16,
  input  logic [25:0] redirect_tgt26,
  input  logic [31:0] redirect_rs,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_err
);

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic             r_squash;
  logic [CNT_W-1:0] r_cnt;
  logic             r_imem_req;
  logic [31:0]      r_imem_addr;
  logic             r_inst_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic             r_fetch_err;

  logic [31:0]      w_target;
  logic             w_redir;
  logic [31:0]      w_issue_pc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout;

  next_pc_calc u_next_pc (
    .redirect_src   (redirect_src),
    .redirect_pc    (redirect_pc),
    .redirect_imm16 (redirect_imm16),
    .redirect_tgt26 (redirect_tgt26),
    .redirect_rs    (redirect_rs),
    .target         (w_target)
  );

  assign w_redir    = redirect_valid && (redirect_src != PCSRC_NONE);
  // A redirect this cycle overrides the PC that would otherwise be issued.
  assign w_issue_pc = w_redir ? w_target : r_pc;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_squash     <= 1'b0;
      r_cnt        <= '0;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_fetch_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redir) r_pc <= w_target;
          if (!stall) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_issue_pc;
            r_cnt       <= '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_valid) begin
            r_cnt <= '0;
            if (w_redir || r_squash) begin
              // Returned word belongs to a squashed path: drop it and refetch.
              r_squash <= 1'b0;
              if (w_redir) r_pc <= w_target;
              if (!stall) begin
                r_imem_addr <= w_issue_pc;
              end else begin
                r_imem_req <= 1'b0;
                r_state    <= S_IDLE;
              end
            end else begin
              r_imem_req   <= 1'b0;
              r_inst       <= imem_rdata;
              r_inst_pc    <= r_imem_addr;
              r_inst_valid <= 1'b1;
              r_pc         <= r_pc + 32'd1;
              r_state      <= S_HOLD;
            end
          end else if (w_timeout) begin
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b1;
            r_state      <= S_ERR;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_redir) begin
              r_pc     <= w_target;
              r_squash <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_redir || inst_ready) begin
            r_inst_valid <= 1'b0;
            if (w_redir) r_pc <= w_target;
            if (!stall) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_issue_pc;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
          r_fetch_err  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_err  = r_fetch_err;

endmodule
